// File: rtl/uart_pkg.sv
// Shared UART definitions: state encoding, default bit timing and data width.
// Used by both the receiver and the transmitter.
package uart_pkg;

   localparam int CLKS_PER_BIT_DEF = 87;
   localparam int DATA_W           = 8;

   typedef enum logic [2:0] {
      IDLE       = 3'd0,
      START      = 3'd1,
      DATA       = 3'd2,
      PARITY     = 3'd3,
      STOP       = 3'd4,
      CLEANUP    = 3'd5,
      BREAK_WAIT = 3'd6
   } uart_state_e;

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for an asynchronous single-bit input.
// Reset value is a parameter so idle-high and idle-low lines both fit.
module uart_sync2 #(
   parameter logic RST_VAL = 1'b1
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic d_i,
   output logic q_o
);

   logic ff1_q;
   logic ff2_q;

   // metastability filter: two back-to-back flops
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         ff1_q <= RST_VAL;
         ff2_q <= RST_VAL;
      end else begin
         ff1_q <= d_i;
         ff2_q <= ff1_q;
      end
   end

   assign q_o = ff2_q;

endmodule

// File: rtl/uart_rx_basic.sv
// 8N1 UART receiver, LSB first, mid-bit sampling on a synchronized line.
// Optional even parity bit between data and stop when UART_RX_PARITY_EN is defined.
module uart_rx_basic
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
   parameter int CNT_W        = 16
) (
   input  logic              i_Clock,
   input  logic              i_Reset,
   input  logic              i_Rx_Serial,
   output logic              o_Rx_DV,
   output logic [DATA_W-1:0] o_Rx_Byte,
   output logic              o_Rx_Active,
   output logic              o_Frame_Err,
   output logic              o_Parity_Err
);

   localparam logic [CNT_W-1:0] MID_LIM  = CNT_W'((CLKS_PER_BIT - 1) / 2);
   localparam logic [CNT_W-1:0] FULL_LIM = CNT_W'(CLKS_PER_BIT - 1);

   logic              rx_s;
   uart_state_e       state_q;
   logic [CNT_W-1:0]  cnt_q;
   logic [2:0]        idx_q;
   logic [DATA_W-1:0] shift_q;
   logic [DATA_W-1:0] byte_q;
   logic              dv_q;
   logic              active_q;
   logic              frame_err_q;
`ifdef UART_RX_PARITY_EN
   logic              par_bit_q;
   logic              parity_err_q;
`endif

   uart_sync2 #(.RST_VAL(1'b1)) u_sync (
      .clk_i (i_Clock),
      .rst_i (i_Reset),
      .d_i   (i_Rx_Serial),
      .q_o   (rx_s)
   );

   // receive FSM with registered strobes, byte and activity flag
   always_ff @(posedge i_Clock) begin
      if (i_Reset) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         idx_q       <= 3'd0;
         shift_q     <= '0;
         byte_q      <= 8'h00;
         dv_q        <= 1'b0;
         active_q    <= 1'b0;
         frame_err_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
         par_bit_q    <= 1'b0;
         parity_err_q <= 1'b0;
`endif
      end else begin
         dv_q        <= 1'b0;
         frame_err_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
         parity_err_q <= 1'b0;
`endif
         case (state_q)
            IDLE: begin
               cnt_q <= '0;
               idx_q <= 3'd0;
               if (!rx_s) state_q <= START;
            end
            START: begin
               if (cnt_q == MID_LIM) begin
                  cnt_q <= '0;
                  if (!rx_s) begin
                     state_q  <= DATA;
                     idx_q    <= 3'd0;
                     active_q <= 1'b1;
                  end else begin
                     state_q <= IDLE;
                  end
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            DATA: begin
               if (cnt_q == FULL_LIM) begin
                  cnt_q          <= '0;
                  shift_q[idx_q] <= rx_s;
                  if (idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                     state_q <= PARITY;
`else
                     state_q <= STOP;
`endif
                  end else begin
                     idx_q <= idx_q + 3'd1;
                  end
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
               if (cnt_q == FULL_LIM) begin
                  cnt_q     <= '0;
                  par_bit_q <= rx_s;
                  state_q   <= STOP;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
`endif
            STOP: begin
               if (cnt_q == FULL_LIM) begin
                  cnt_q <= '0;
                  if (rx_s) begin
                     byte_q  <= shift_q;
                     dv_q    <= 1'b1;
                     state_q <= CLEANUP;
`ifdef UART_RX_PARITY_EN
                     parity_err_q <= ^{shift_q, par_bit_q};
`endif
                  end else begin
                     frame_err_q <= 1'b1;
                     state_q     <= BREAK_WAIT;
                  end
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            // a start edge already visible here skips IDLE to keep back-to-back timing
            CLEANUP: begin
               active_q <= 1'b0;
               cnt_q    <= '0;
               state_q  <= rx_s ? IDLE : START;
            end
            BREAK_WAIT: begin
               if (rx_s) begin
                  active_q <= 1'b0;
                  state_q  <= IDLE;
               end
            end
            default: begin
               active_q <= 1'b0;
               cnt_q    <= '0;
               state_q  <= IDLE;
            end
         endcase
      end
   end

   assign o_Rx_DV     = dv_q;
   assign o_Rx_Byte   = byte_q;
   assign o_Rx_Active = active_q;
   assign o_Frame_Err = frame_err_q;
`ifdef UART_RX_PARITY_EN
   assign o_Parity_Err = parity_err_q;
`else
   assign o_Parity_Err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_basic.sv
// Self-checking bench for uart_rx_basic: a behavioural serial driver, a strobe
// monitor and expected-byte queues; random bytes exercise the loopback path.
`timescale 1ns/1ps
module tb_uart_rx_basic;

   localparam int CPB = 87;
`ifdef UART_RX_PARITY_EN
   localparam int PB = 1;
`else
   localparam int PB = 0;
`endif

   logic       clk = 1'b0;
   logic       rst;
   logic       rx;
   logic       dv;
   logic [7:0] rbyte;
   logic       active;
   logic       ferr;
   logic       perr;

   int total = 0;
   int bad   = 0;

   logic [7:0] rx_q[$];
   logic       pe_q[$];
   logic [7:0] exp_q[$];
   logic       exp_pe_q[$];
   int         fe_cnt      = 0;
   int         both_cnt    = 0;
   int         stray_pe    = 0;
   bit         active_seen = 1'b0;
   realtime    t_dv;
   realtime    t_start;
   logic [7:0] last_good;

   always #50 clk = ~clk;

   uart_rx_basic #(.CLKS_PER_BIT(CPB), .CNT_W(16)) dut (
      .i_Clock      (clk),
      .i_Reset      (rst),
      .i_Rx_Serial  (rx),
      .o_Rx_DV      (dv),
      .o_Rx_Byte    (rbyte),
      .o_Rx_Active  (active),
      .o_Frame_Err  (ferr),
      .o_Parity_Err (perr)
   );

   always @(negedge clk) begin
      if (dv) begin
         rx_q.push_back(rbyte);
         pe_q.push_back(perr);
         t_dv = $realtime;
      end
      if (ferr) fe_cnt++;
      if (dv && ferr) both_cnt++;
      if (perr && !dv) stray_pe++;
      if (active) active_seen = 1'b1;
   end

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic send_bit(input logic v);
      rx = v;
      repeat (CPB) @(negedge clk);
   endtask

   // Frame driver: rst_bit >= 0 pulses reset for 2 cycles halfway through that data bit
   task automatic send_frame(input logic [7:0] b, input logic stop_v,
                             input logic par_flip, input int rst_bit);
      t_start = $realtime;
      send_bit(1'b0);
      for (int i = 0; i < 8; i++) begin
         if (i == rst_bit) begin
            rx = b[i];
            repeat (CPB / 2) @(negedge clk);
            rst = 1'b1;
            repeat (2) @(negedge clk);
            rst = 1'b0;
            repeat (CPB - CPB / 2 - 2) @(negedge clk);
         end else begin
            send_bit(b[i]);
         end
      end
      if (PB == 1) send_bit((^b) ^ par_flip);
      send_bit(stop_v);
   endtask

   task automatic expect_byte(input logic [7:0] b, input logic pe);
      exp_q.push_back(b);
      exp_pe_q.push_back(pe);
      last_good = b;
   endtask

   task automatic drain(input string tag);
      check_val({tag, "_count"}, rx_q.size(), exp_q.size());
      while (rx_q.size() > 0 && exp_q.size() > 0) begin
         check_val({tag, "_byte"}, rx_q.pop_front(), exp_q.pop_front());
         check_val({tag, "_perr"}, pe_q.pop_front(), exp_pe_q.pop_front());
      end
      rx_q.delete();
      pe_q.delete();
      exp_q.delete();
      exp_pe_q.delete();
   endtask

   initial begin
      real lat;
      real nom;
      int  fe_before;
      logic [7:0] rb;

      rx  = 1'b1;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      check_val("rst_dv", dv, 1'b0);
      check_val("rst_byte", rbyte, 8'h00);
      check_val("rst_active", active, 1'b0);
      check_val("rst_ferr", ferr, 1'b0);
      check_val("rst_perr", perr, 1'b0);
      rst = 1'b0;
      repeat (10) @(negedge clk);

      // single frame, latency and activity flag
      send_frame(8'hAB, 1'b1, 1'b0, -1);
      expect_byte(8'hAB, 1'b0);
      lat = (t_dv - t_start) / 100.0;
      nom = 2.0 + (9.5 + PB) * CPB;
      check_val("latency_in_window", (lat >= nom - 3.0 && lat <= nom + 3.0), 1'b1);
      repeat (2 * CPB) @(negedge clk);
      check_val("active_seen", active_seen, 1'b1);
      check_val("active_low_after", active, 1'b0);
      check_val("ferr_none_ab", fe_cnt, 0);
      drain("ab");

      // back-to-back frames, no idle gap
      send_frame(8'h00, 1'b1, 1'b0, -1); expect_byte(8'h00, 1'b0);
      send_frame(8'hFF, 1'b1, 1'b0, -1); expect_byte(8'hFF, 1'b0);
      send_frame(8'h55, 1'b1, 1'b0, -1); expect_byte(8'h55, 1'b0);
      repeat (2 * CPB) @(negedge clk);
      drain("b2b");

      // 2000 ns glitch on an idle line
      rx = 1'b0;
      repeat (20) @(negedge clk);
      rx = 1'b1;
      repeat (45) @(negedge clk);
      check_val("glitch_active", active, 1'b0);
      check_val("glitch_ferr", fe_cnt, 0);
      drain("glitch");

      // bad stop bit, long break, then a good frame
      fe_before = fe_cnt;
      send_frame(8'h3C, 1'b0, 1'b0, -1);
      repeat (20 * CPB) @(negedge clk);
      check_val("ferr_pulse", fe_cnt, fe_before + 1);
      check_val("ferr_byte_held", rbyte, last_good);
      send_bit(1'b1);
      send_frame(8'h81, 1'b1, 1'b0, -1); expect_byte(8'h81, 1'b0);
      repeat (2 * CPB) @(negedge clk);
      check_val("ferr_once", fe_cnt, fe_before + 1);
      drain("break");

      // reset in the middle of bit 4
      fe_before = fe_cnt;
      send_frame(8'hF4, 1'b1, 1'b0, 4);
      repeat (2 * CPB) @(negedge clk);
      check_val("midrst_byte", rbyte, 8'h00);
      check_val("midrst_ferr", fe_cnt, fe_before);
      drain("midrst");
      send_frame(8'hC3, 1'b1, 1'b0, -1); expect_byte(8'hC3, 1'b0);
      repeat (2 * CPB) @(negedge clk);
      drain("after_rst");

      // transmitter-style loopback: 0xAB then 16 random bytes, back-to-back
      send_frame(8'hAB, 1'b1, 1'b0, -1); expect_byte(8'hAB, 1'b0);
      for (int i = 0; i < 16; i++) begin
         rb = 8'($urandom_range(0, 255));
         send_frame(rb, 1'b1, 1'b0, -1);
         expect_byte(rb, 1'b0);
      end
      repeat (2 * CPB) @(negedge clk);
      drain("loop");

`ifdef UART_RX_PARITY_EN
      // wrong parity bit: byte still delivered with the error strobe
      send_frame(8'hAB, 1'b1, 1'b1, -1); expect_byte(8'hAB, 1'b1);
      repeat (2 * CPB) @(negedge clk);
      drain("parity");
`endif

      check_val("dv_ferr_exclusive", both_cnt, 0);
      check_val("perr_without_dv", stray_pe, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #50ms;
      $display("FAIL timeout: simulation exceeded its time limit");
      $fatal(1);
   end

endmodule
